fpu_mc: RTL



---
 rtl/fpu_mc_pkg.sv | 82 ++++++++
 rtl/fpu_mc_core.sv | 225 ++++++++++++++++++++++
 rtl/fpu_mc.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/fpu_mc_pkg.sv
// fpu_mc_pkg: shared types and helpers for the multicycle single-precision FPU.
//   fpu_op_e   - 4-bit opcode (12..15 are illegal)
//   state_e    - request FSM states
//   unit_res_t - result word plus overflow/exception from one arithmetic unit
//   lat_of     - EXEC cycle count of an opcode
//   is_nan / pack_norm - IEEE-754 single helpers shared by the units
package fpu_mc_pkg;

    typedef enum logic [3:0] {
        FADD   = 4'd0,
        FSUB   = 4'd1,
        FMUL   = 4'd2,
        FDIV   = 4'd3,
        FSQRT  = 4'd4,
        FEQ    = 4'd5,
        FLT    = 4'd6,
        FLE    = 4'd7,
        FCVTWS = 4'd8,
        FSGNJ  = 4'd9,
        FSGNJX = 4'd10,
        FSGNJN = 4'd11
    } fpu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int FFLAG_OVF = 0;
    localparam int FFLAG_EXC = 1;
    localparam int FFLAG_ILL = 2;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef struct packed {
        logic [31:0] y;
        logic        ovf;
        logic        exc;
    } unit_res_t;

    // Number of EXEC cycles for an opcode; illegal opcodes use the misc latency.
    function automatic logic [7:0] lat_of(input logic [3:0] op,
                                          input logic [7:0] add_lat,
                                          input logic [7:0] mul_lat,
                                          input logic [7:0] div_lat,
                                          input logic [7:0] sqrt_lat,
                                          input logic [7:0] misc_lat);
        logic [7:0] lat;
        case (op)
            FADD, FSUB: lat = add_lat;
            FMUL:       lat = mul_lat;
            FDIV:       lat = div_lat;
            FSQRT:      lat = sqrt_lat;
            default:    lat = misc_lat;
        endcase
        return lat;
    endfunction

    function automatic logic is_nan(input logic [31:0] a);
        return (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    endfunction

    // Pack a normalised mantissa (bit 23 = hidden one) with a signed biased
    // exponent; overflow saturates to infinity, underflow flushes to zero.
    function automatic unit_res_t pack_norm(input logic s,
                                            input logic signed [9:0] ex,
                                            input logic [23:0] mant);
        unit_res_t r;
        r = '0;
        if (ex >= 10'sd255) begin
            r.y   = {s, 8'hFF, 23'd0};
            r.ovf = 1'b1;
        end else if (ex <= 10'sd0) begin
            r.y = {s, 31'd0};
        end else begin
            r.y = {s, ex[7:0], mant[22:0]};
        end
        return r;
    endfunction

endpackage

// File: rtl/fpu_mc_core.sv
// fpu_mc_core: purely combinational FP datapath fed by the operand registers.
// Every path from the operand inputs to the outputs is a multicycle path of
// lat_of(op) cycles. Denormal inputs are treated as zero; results truncate.
//   op_i         - opcode (fpu_op_e, 12..15 illegal)
//   x1_i, x2_i   - IEEE single operands
//   y_o          - result word
//   ovf_o/exc_o  - overflow (add/sub/mul/div), exception (feq/fsqrt/fcvtws)
//   ill_o        - illegal opcode
module fpu_mc_core
    import fpu_mc_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [31:0] x1_i,
    input  logic [31:0] x2_i,
    output logic [31:0] y_o,
    output logic        ovf_o,
    output logic        exc_o,
    output logic        ill_o
);

    function automatic unit_res_t f_add(input logic [31:0] a, input logic [31:0] b);
        unit_res_t         r;
        logic [31:0]       big, sml;
        logic [24:0]       mb, ms, sum;
        logic [7:0]        d;
        logic signed [9:0] ex;
        logic [23:0]       mant;
        logic [4:0]        lz;
        logic              found;
        r = '0;
        if (is_nan(a) || is_nan(b)) begin
            r.y = QNAN;
        end else if (a[30:23] == 8'hFF) begin
            r.y = a;
        end else if (b[30:23] == 8'hFF) begin
            r.y = b;
        end else begin
            // Larger magnitude first so the difference is never negative.
            if (a[30:0] >= b[30:0]) begin
                big = a; sml = b;
            end else begin
                big = b; sml = a;
            end
            mb  = {1'b0, big[30:23] != 8'd0, big[22:0]};
            ms  = {1'b0, sml[30:23] != 8'd0, sml[22:0]};
            d   = big[30:23] - sml[30:23];
            ms  = ms >> d;
            sum = (big[31] == sml[31]) ? (mb + ms) : (mb - ms);
            ex  = $signed({2'b00, big[30:23]});
            if (sum == 25'd0) begin
                r.y = 32'd0;
            end else if (sum[24]) begin
                r = pack_norm(big[31], ex + 10'sd1, sum[24:1]);
            end else begin
                mant  = sum[23:0];
                lz    = 5'd0;
                found = 1'b0;
                for (int i = 23; i >= 0; i--) begin
                    if (!found && !mant[i]) lz = lz + 5'd1;
                    else found = 1'b1;
                end
                r = pack_norm(big[31], ex - $signed({5'd0, lz}), mant << lz);
            end
        end
        return r;
    endfunction

    function automatic unit_res_t f_mul(input logic [31:0] a, input logic [31:0] b);
        unit_res_t         r;
        logic              s;
        logic [47:0]       p;
        logic signed [9:0] ex;
        r = '0;
        s = a[31] ^ b[31];
        if (is_nan(a) || is_nan(b)) begin
            r.y = QNAN;
        end else if ((a[30:23] == 8'hFF) || (b[30:23] == 8'hFF)) begin
            r.y = ((a[30:23] == 8'd0) || (b[30:23] == 8'd0)) ? QNAN : {s, 8'hFF, 23'd0};
        end else if ((a[30:23] == 8'd0) || (b[30:23] == 8'd0)) begin
            r.y = {s, 31'd0};
        end else begin
            p  = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
            ex = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
            if (p[47]) r = pack_norm(s, ex + 10'sd1, p[47:24]);
            else       r = pack_norm(s, ex, p[46:23]);
        end
        return r;
    endfunction

    function automatic unit_res_t f_div(input logic [31:0] a, input logic [31:0] b);
        unit_res_t         r;
        logic              s;
        logic [47:0]       q;
        logic signed [9:0] ex;
        r = '0;
        s = a[31] ^ b[31];
        if (is_nan(a) || is_nan(b)) begin
            r.y = QNAN;
        end else if (b[30:23] == 8'd0) begin
            // x/0 saturates to infinity and reports overflow; 0/0 is NaN.
            r.y   = (a[30:23] == 8'd0) ? QNAN : {s, 8'hFF, 23'd0};
            r.ovf = (a[30:23] != 8'd0);
        end else if (a[30:23] == 8'hFF) begin
            r.y = (b[30:23] == 8'hFF) ? QNAN : {s, 8'hFF, 23'd0};
        end else if ((a[30:23] == 8'd0) || (b[30:23] == 8'hFF)) begin
            r.y = {s, 31'd0};
        end else begin
            // Quotient of the 24-bit mantissas scaled by 2^24 lies in (2^23, 2^25).
            q  = {1'b1, a[22:0], 24'd0} / {24'd0, 1'b1, b[22:0]};
            ex = $signed({2'b00, a[30:23]}) - $signed({2'b00, b[30:23]}) + 10'sd127;
            if (q[24]) r = pack_norm(s, ex, q[24:1]);
            else       r = pack_norm(s, ex - 10'sd1, q[23:0]);
        end
        return r;
    endfunction

    function automatic logic [23:0] isqrt48(input logic [47:0] v);
        logic [23:0] root, cand;
        root = 24'd0;
        for (int i = 23; i >= 0; i--) begin
            cand = root | (24'd1 << i);
            if (({24'd0, cand} * {24'd0, cand}) <= v) root = cand;
            else root = root;
        end
        return root;
    endfunction

    function automatic unit_res_t f_sqrt(input logic [31:0] a);
        unit_res_t         r;
        logic signed [9:0] e_unb;
        logic              odd;
        logic [47:0]       rad;
        r = '0;
        if (is_nan(a)) begin
            r.y = QNAN; r.exc = 1'b1;
        end else if (a[30:23] == 8'd0) begin
            r.y = {a[31], 31'd0};
        end else if (a[31]) begin
            r.y = QNAN; r.exc = 1'b1;
        end else if (a[30:23] == 8'hFF) begin
            r.y = a;
        end else begin
            // Make the exponent even by folding an odd bit into the radicand.
            e_unb = $signed({2'b00, a[30:23]}) - 10'sd127;
            odd   = e_unb[0];
            rad   = odd ? {1'b1, a[22:0], 24'd0} : {1'b0, 1'b1, a[22:0], 23'd0};
            r     = pack_norm(1'b0, ((e_unb - $signed({9'd0, odd})) >>> 1) + 10'sd127,
                              isqrt48(rad));
        end
        return r;
    endfunction

    function automatic unit_res_t f_eq(input logic [31:0] a, input logic [31:0] b);
        unit_res_t r;
        r = '0;
        if (is_nan(a) || is_nan(b)) begin
            r.exc = 1'b1;
        end else begin
            r.y[0] = (a == b) || ((a[30:0] == 31'd0) && (b[30:0] == 31'd0));
        end
        return r;
    endfunction

    function automatic logic f_lt(input logic [31:0] a, input logic [31:0] b);
        logic lt;
        if (is_nan(a) || is_nan(b))                         lt = 1'b0;
        else if ((a[30:0] == 31'd0) && (b[30:0] == 31'd0))  lt = 1'b0;
        else if (a[31] != b[31])                            lt = a[31];
        else if (a[31])                                     lt = a[30:0] > b[30:0];
        else                                                lt = a[30:0] < b[30:0];
        return lt;
    endfunction

    function automatic unit_res_t f_cvt(input logic [31:0] a);
        unit_res_t   r;
        logic [7:0]  e_unb;
        logic [31:0] mag;
        r     = '0;
        e_unb = a[30:23] - 8'd127;
        if (is_nan(a)) begin
            r.y = 32'h7FFF_FFFF; r.exc = 1'b1;
        end else if (a[30:23] < 8'd127) begin
            r.y = 32'd0;
        end else if (e_unb >= 8'd31) begin
            r.y   = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            r.exc = 1'b1;
        end else begin
            mag = {8'd0, 1'b1, a[22:0]};
            if (e_unb >= 8'd23) mag = mag << (e_unb - 8'd23);
            else                mag = mag >> (8'd23 - e_unb);
            r.y = a[31] ? (32'd0 - mag) : mag;
        end
        return r;
    endfunction

    unit_res_t res_s;
    logic      ill_s;

    // Result/flag mux; each unit only reports the flag it owns.
    always_comb begin
        res_s = '0;
        ill_s = 1'b0;
        case (op_i)
            FADD:    res_s = f_add(x1_i, x2_i);
            FSUB:    res_s = f_add(x1_i, {~x2_i[31], x2_i[30:0]});
            FMUL:    res_s = f_mul(x1_i, x2_i);
            FDIV:    res_s = f_div(x1_i, x2_i);
            FSQRT:   res_s = f_sqrt(x1_i);
            FEQ:     res_s = f_eq(x1_i, x2_i);
            FLT:     res_s.y = {31'd0, f_lt(x1_i, x2_i)};
            FLE:     res_s.y = {31'd0, f_lt(x1_i, x2_i) | f_eq(x1_i, x2_i).y[0]};
            FCVTWS:  res_s = f_cvt(x1_i);
            FSGNJ:   res_s.y = {x2_i[31], x1_i[30:0]};
            FSGNJX:  res_s.y = {x1_i[31] ^ x2_i[31], x1_i[30:0]};
            FSGNJN:  res_s.y = {~x2_i[31], x1_i[30:0]};
            default: ill_s = 1'b1;
        endcase
    end

    assign y_o   = res_s.y;
    assign ovf_o = res_s.ovf;
    assign exc_o = res_s.exc;
    assign ill_o = ill_s;

endmodule

// File: rtl/fpu_mc.sv
// fpu_mc: multicycle handshaked single-precision FPU.
//   clk, rst (async, active-low)
//   req_valid/req_ready/req_op/req_x1/req_x2/req_tag - request channel
//   resp_valid/resp_ready/resp_y/resp_tag/resp_ovf/resp_exc/resp_ill - response
//   flush      - abandon the in-flight op (no response, no flag update)
//   fflags_clr - clear the sticky flags; fflags = sticky {ill, exc, ovf}
module fpu_mc
    import fpu_mc_pkg::*;
#(
    parameter int TAG_W    = 4,
    parameter int ADD_LAT  = 2,
    parameter int MUL_LAT  = 2,
    parameter int DIV_LAT  = 8,
    parameter int SQRT_LAT = 8,
    parameter int MISC_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [31:0]      req_x1,
    input  logic [31:0]      req_x2,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_y,
    output logic [TAG_W-1:0] resp_tag,
    output logic             resp_ovf,
    output logic             resp_exc,
    output logic             resp_ill,
    input  logic             flush,
    input  logic             fflags_clr,
    output logic [2:0]       fflags
);

    state_e           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [31:0]      x1_q, x1_d, x2_q, x2_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [31:0]      y_q, y_d;
    logic             ovf_q, ovf_d, exc_q, exc_d, ill_q, ill_d;
    logic [2:0]       fflags_q, fflags_d;
    logic [2:0]       set_s;
    logic             req_ready_s, resp_valid_s, accept_s;
    logic [31:0]      core_y_s;
    logic             core_ovf_s, core_exc_s, core_ill_s;

    fpu_mc_core u_core (
        .op_i  (op_q),
        .x1_i  (x1_q),
        .x2_i  (x2_q),
        .y_o   (core_y_s),
        .ovf_o (core_ovf_s),
        .exc_o (core_exc_s),
        .ill_o (core_ill_s)
    );

    // State, operand, result and sticky-flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            op_q     <= 4'd0;
            x1_q     <= 32'd0;
            x2_q     <= 32'd0;
            tag_q    <= '0;
            y_q      <= 32'd0;
            ovf_q    <= 1'b0;
            exc_q    <= 1'b0;
            ill_q    <= 1'b0;
            fflags_q <= 3'b000;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            x1_q     <= x1_d;
            x2_q     <= x2_d;
            tag_q    <= tag_d;
            y_q      <= y_d;
            ovf_q    <= ovf_d;
            exc_q    <= exc_d;
            ill_q    <= ill_d;
            fflags_q <= fflags_d;
        end
    end

    // Next-state logic: countdown in EXEC, capture on the last EXEC cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        tag_d   = tag_q;
        y_d     = y_q;
        ovf_d   = ovf_q;
        exc_d   = exc_q;
        ill_d   = ill_q;
        set_s   = 3'b000;
        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            EXEC: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (cnt_q == 8'd0) begin
                    state_d = DONE;
                    y_d     = core_y_s;
                    ovf_d   = core_ovf_s;
                    exc_d   = core_exc_s;
                    ill_d   = core_ill_s;
                    set_s[FFLAG_OVF] = core_ovf_s;
                    set_s[FFLAG_EXC] = core_exc_s;
                    set_s[FFLAG_ILL] = core_ill_s;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            DONE: begin
                if (flush || resp_ready) state_d = IDLE;
                else                     state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // An accept (IDLE, or DONE with the response taking) overrides the above.
        if (accept_s) begin
            state_d = EXEC;
            op_d    = req_op;
            x1_d    = req_x1;
            x2_d    = req_x2;
            tag_d   = req_tag;
            cnt_d   = lat_of(req_op, 8'(ADD_LAT), 8'(MUL_LAT), 8'(DIV_LAT),
                             8'(SQRT_LAT), 8'(MISC_LAT)) - 8'd1;
        end else begin
            cnt_d = cnt_d;
        end
        // Bits set this cycle survive a simultaneous clear.
        fflags_d = (fflags_clr ? 3'b000 : fflags_q) | set_s;
    end

    // Handshake outputs; req_ready is held low while reset is asserted.
    always_comb begin
        req_ready_s  = 1'b0;
        resp_valid_s = (state_q == DONE);
        if (rst && !flush) begin
            req_ready_s = (state_q == IDLE) || ((state_q == DONE) && resp_ready);
        end else begin
            req_ready_s = 1'b0;
        end
    end

    assign accept_s   = req_valid && req_ready_s;
    assign req_ready  = req_ready_s;
    assign resp_valid = resp_valid_s;
    assign resp_y     = y_q;
    assign resp_tag   = tag_q;
    assign resp_ovf   = ovf_q;
    assign resp_exc   = exc_q;
    assign resp_ill   = ill_q;
    assign fflags     = fflags_q;

endmodule
